// File: rtl/noc_phase_sequencer_pkg.sv
// Shared constants for the NoC phase sequencer: sizes, broadcast opcodes
// and the controller state encoding.
package noc_phase_sequencer_pkg;

    localparam int unsigned MAX_ROUTER    = 8;
    localparam int unsigned IN_CYCLE_SIZE = 16;
    localparam int unsigned OP_SIZE       = 2;

    localparam logic [OP_SIZE-1:0] OP_NOP          = 2'd0;
    localparam logic [OP_SIZE-1:0] OP_LOAD_STAGING = 2'd1;
    localparam logic [OP_SIZE-1:0] OP_PHASE0       = 2'd2;
    localparam logic [OP_SIZE-1:0] OP_PHASE1       = 2'd3;

    localparam int unsigned STATE_BIT = 3;

    typedef enum logic [STATE_BIT-1:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_PH0    = 3'd2,
        ST_PH1    = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

endpackage

// File: rtl/noc_phase_sequencer_if.sv
// Run-control and router-broadcast signals of the phase sequencer.
// The master side is the run controller / router array, the slave side is
// the sequencer itself.
interface noc_phase_sequencer_if #(
    parameter int unsigned NUM_ROUTERS = 8,
    parameter int unsigned CYCLE_W     = 16,
    parameter int unsigned OP_W        = 2
);
    logic                   start;
    logic                   stop;
    logic [CYCLE_W-1:0]     max_cycles;
    logic [NUM_ROUTERS-1:0] done_vec;
    logic [OP_W-1:0]        op;
    logic                   load_staging;
    logic [CYCLE_W-1:0]     in_cycle;
    logic                   busy;
    logic                   finished;
    logic                   timeout;

    modport master (
        output start, stop, max_cycles, done_vec,
        input  op, load_staging, in_cycle, busy, finished, timeout
    );

    modport slave (
        input  start, stop, max_cycles, done_vec,
        output op, load_staging, in_cycle, busy, finished, timeout
    );
endinterface

// File: rtl/noc_phase_sequencer_cycle_budget_counter.sv
// Network cycle counter with latched budget and terminal-count compare.
// The count wraps modulo 2^CYCLE_W; a zero budget never reports a hit.
module cycle_budget_counter #(
    parameter int unsigned CYCLE_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic               i_inc,
    input  logic [CYCLE_W-1:0] i_max_cycles,
    output logic [CYCLE_W-1:0] o_in_cycle,
    output logic               o_budget_hit
);
    logic [CYCLE_W-1:0] r_count;
    logic [CYCLE_W-1:0] r_budget;
    logic [CYCLE_W-1:0] w_next;

    assign w_next = r_count + CYCLE_W'(1);

    // Clear and latch the budget at run start, otherwise advance on request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_budget <= '0;
        end else if (i_clear) begin
            r_count  <= '0;
            r_budget <= i_max_cycles;
        end else if (i_inc) begin
            r_count  <= w_next;
        end
    end

    assign o_in_cycle   = r_count;
    assign o_budget_hit = (r_budget != '0) && (w_next == r_budget);
endmodule

// File: rtl/noc_phase_sequencer.sv
// Steps all routers through LoadStaging -> Phase0 -> Phase1 each network
// cycle, strobes the staging exchange and ends the run on all-done, stop or
// budget exhaustion.
module noc_phase_sequencer
    import noc_phase_sequencer_pkg::*;
#(
    parameter int unsigned NUM_ROUTERS = MAX_ROUTER,
    parameter int unsigned CYCLE_W     = IN_CYCLE_SIZE,
    parameter int unsigned OP_W        = OP_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    noc_phase_sequencer_if.slave bus
);
    state_t                 r_state;
    logic [OP_W-1:0]        r_op;
    logic                   r_load_staging;
    logic                   r_busy;
    logic                   r_finished;
    logic                   r_timeout;

    logic [NUM_ROUTERS-1:0] w_done_vec;
    logic                   w_all_done;
    logic                   w_clear;
    logic                   w_inc;
    logic                   w_budget_hit;
    logic [CYCLE_W-1:0]     w_in_cycle;

    assign w_done_vec = bus.done_vec;
    assign w_all_done = &w_done_vec;
    assign w_clear    = (r_state == ST_IDLE) && bus.start;
    // All-done ends the run without counting the final cycle.
    assign w_inc      = (r_state == ST_PH1) && !w_all_done;

    cycle_budget_counter #(
        .CYCLE_W (CYCLE_W)
    ) u_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_clear),
        .i_inc        (w_inc),
        .i_max_cycles (bus.max_cycles),
        .o_in_cycle   (w_in_cycle),
        .o_budget_hit (w_budget_hit)
    );

    // Phase FSM; outputs are registered alongside the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_op           <= OP_W'(OP_NOP);
            r_load_staging <= 1'b0;
            r_busy         <= 1'b0;
            r_finished     <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state        <= ST_LOAD;
                        r_op           <= OP_W'(OP_LOAD_STAGING);
                        r_load_staging <= 1'b1;
                        r_busy         <= 1'b1;
                        r_timeout      <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    r_state        <= ST_PH0;
                    r_op           <= OP_W'(OP_PHASE0);
                    r_load_staging <= 1'b0;
                end
                ST_PH0: begin
                    r_state <= ST_PH1;
                    r_op    <= OP_W'(OP_PHASE1);
                end
                ST_PH1: begin
                    if (w_all_done || bus.stop || w_budget_hit) begin
                        r_state    <= ST_FINISH;
                        r_op       <= OP_W'(OP_NOP);
                        r_busy     <= 1'b0;
                        r_finished <= 1'b1;
                        r_timeout  <= !w_all_done && !bus.stop;
                    end else begin
                        r_state        <= ST_LOAD;
                        r_op           <= OP_W'(OP_LOAD_STAGING);
                        r_load_staging <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    if (!bus.start) begin
                        r_state    <= ST_IDLE;
                        r_finished <= 1'b0;
                    end
                end
                default: begin
                    r_state        <= ST_IDLE;
                    r_op           <= OP_W'(OP_NOP);
                    r_load_staging <= 1'b0;
                    r_busy         <= 1'b0;
                    r_finished     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.op           = r_op;
    assign bus.load_staging = r_load_staging;
    assign bus.in_cycle     = w_in_cycle;
    assign bus.busy         = r_busy;
    assign bus.finished     = r_finished;
    assign bus.timeout      = r_timeout;
endmodule

// File: doc/noc_phase_sequencer.md
# noc_phase_sequencer

Synchronous controller that steps every router in the NoC through its per-cycle phase sequence: LoadStaging, then Phase0, then Phase1. It broadcasts the phase opcode to all routers and strobes the inter-router staging exchange. It maintains the network cycle counter `in_cycle` and stops the simulation when all routers report done or a cycle budget is exhausted. It sits at the top level, between the run-control interface and the array of router instances.

## Interface
Parameters:
- `NUM_ROUTERS`, default `` `max_router ``: number of routers in the done vector.
- `CYCLE_W`, default `` `in_cycle_size ``: width of the cycle counter and the budget.
- `OP_W`, default `` `op_size ``: width of the broadcast opcode.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; sampled only in IDLE.
- `stop`  in  1  level; requests an orderly halt at the next cycle boundary.
- `max_cycles`  in  CYCLE_W  cycle budget, sampled when `start` is accepted. A value of 0 means unlimited.
- `done_vec`  in  NUM_ROUTERS  per-router done flags.
- `op`  out  OP_W  registered phase opcode, broadcast to all routers.
- `load_staging`  out  1  one-cycle strobe that tells the top level to copy `out_staging` to `in_staging` (and the credit staging in the reverse direction).
- `in_cycle`  out  CYCLE_W  current network cycle.
- `busy`  out  1  high in any state other than IDLE or FINISH.
- `finished`  out  1  high in FINISH.
- `timeout`  out  1  sticky; set when the run ended on the cycle budget.

## Operation
- **States:** IDLE, LOAD, PH0, PH1, FINISH.
- **`op` value per state:**
  - IDLE → `NOP`
  - LOAD → `LoadStaging`
  - PH0 → `Phase0`
  - PH1 → `Phase1`
  - FINISH → `NOP`
- **IDLE:** on `start`, clear `in_cycle` and `timeout`, latch `max_cycles`, go to LOAD.
- **LOAD:** assert `load_staging`, go to PH0.
- **PH0:** go to PH1.
- **PH1:** the cycle-boundary decision, evaluated in priority order:
  1. `&done_vec` → FINISH. `in_cycle` is not incremented.
  2. `stop` → FINISH, with `in_cycle` incremented.
  3. Budget nonzero and `in_cycle+1 == budget` → FINISH, with `in_cycle` incremented and `timeout` set.
  4. Otherwise → LOAD, with `in_cycle` incremented.
- **FINISH:** hold until `start` is deasserted, then go to IDLE. This prevents an immediate restart from a held `start`.
- **`done_vec`:** sampled only in PH1. Mid-cycle toggles are ignored.
- **`in_cycle` arithmetic:** modulo 2^CYCLE_W. With budget 0 it wraps silently from all-ones to 0.
- **`stop` outside PH1:** ignored in IDLE. In LOAD or PH0 it is not latched; only its level in PH1 matters.
- **Simultaneous events in PH1:** done and budget both true → the done path is taken and `timeout` stays 0. `stop` and budget both true → the stop path is taken and `timeout` stays 0.
- **Reset mid-run:** state goes to IDLE, outputs go to reset values, and no partial phase completes.

## Timing
- **Reset values:**
  - `op` = `NOP`
  - `load_staging` = 0
  - `in_cycle` = 0
  - `busy` = 0
  - `finished` = 0
  - `timeout` = 0
- **Outputs:** all registered and decoded from the state register, so each is valid in the cycle the state is entered.
- **`start` latency:** `start` high in IDLE at edge N gives `op` = `LoadStaging` and `load_staging` = 1 from edge N.
- **Cycle length:** one network cycle is exactly 3 clocks (LOAD, PH0, PH1).
- **`in_cycle` update:** increments on the PH1→LOAD edge, so it is stable across LOAD, PH0 and PH1 of a cycle.
- **`load_staging`:** high for exactly 1 clock per network cycle, coincident with `op` = `LoadStaging`.
- **Routers:** must see `Phase1` for one full clock before the done sample takes effect. The `done_vec` value present during PH1 is used at the edge leaving PH1.

## Structure
- **`parameters.v` owns:**
  - the opcode values `NOP`, `LoadStaging`, `Phase0`, `Phase1`;
  - the state encoding defines (IDLE, LOAD, PH0, PH1, FINISH) with `State_bit` width;
  - `op_size`, `in_cycle_size` and `max_router`.
- **Sub-module:** one, `cycle_budget_counter`, holding the counter, the latched budget, the increment enable and the terminal-count compare. It outputs `in_cycle` and `budget_hit`.
- **FSM:** stays in `noc_phase_sequencer`.

## Test plan
- **Reset and start:**
  - Stimulus: assert `rst_n` low mid-PH0 during a run.
  - Required: all outputs return to reset values immediately.
  - Stimulus: then `start`=1.
  - Required: `op` sequence LoadStaging, Phase0, Phase1 repeating; `load_staging` pulses every 3rd clock.
- **Budget:**
  - Stimulus: `max_cycles`=4, `done_vec`=0.
  - Required: FINISH after 12 clocks, `in_cycle`=4, `timeout`=1.
- **Done:**
  - Stimulus: `done_vec` all-ones raised during PH1 of cycle 2.
  - Required: FINISH, `in_cycle`=2, `timeout`=0.
  - Stimulus: a done pulse only in PH0.
  - Required: ignored.
- **Simultaneous events:**
  - Stimulus: `max_cycles`=3 with all-done in PH1 of cycle 2.
  - Required: `timeout`=0.
  - Stimulus: `stop` at the same boundary as the budget hit.
  - Required: `timeout`=0, `in_cycle`=3.
- **Wrap:**
  - Stimulus: CYCLE_W=4, budget 0, run 17 cycles.
  - Required: `in_cycle` goes 15→0→1 with no FINISH.
- **Restart:**
  - Stimulus: `start` held high through FINISH.
  - Required: the sequencer stays in FINISH.
  - Stimulus: drop `start`, then raise it.
  - Required: a new run begins with `in_cycle`=0.
